// File: rtl/spi_protocol_monitor.sv
// spi_protocol_monitor: passive SPI frame decoder and protocol checker.
// Define SPI_MON_ASSERT_EN to add simulation-only assertions and covers for each violation.
module spi_protocol_monitor #(
    parameter int                  CMD_BITS  = 3,
    parameter int                  DATA_BITS = 8,
    parameter logic [CMD_BITS-1:0] READ_CMD  = 3'b111,
    parameter int                  RESP_LAT  = 1,
    parameter int                  MAX_TAIL  = 4,
    parameter int                  CNT_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_mosi,
    input  logic                 i_miso,
    input  logic                 i_ss_n,
    input  logic                 i_err_clr,
    output logic                 o_frame_done,
    output logic [CMD_BITS-1:0]  o_frame_cmd,
    output logic [DATA_BITS-1:0] o_frame_data,
    output logic [DATA_BITS-1:0] o_frame_resp,
    output logic [3:0]           o_err_flags,
    output logic [CNT_W-1:0]     o_err_count,
    output logic [CNT_W-1:0]     o_frame_count
);
    localparam int CW = $clog2(CMD_BITS + DATA_BITS + RESP_LAT + MAX_TAIL + 2);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_RESP, S_END} state_t;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt, w_cnt_last;
    logic                 r_ss_q, r_miso_q, r_rst_q;
    logic [CMD_BITS-1:0]  r_cmd;
    logic [DATA_BITS-1:0] r_data, r_resp;
    logic                 w_fall, w_last, w_window, w_done, w_resp_done, w_resp_cap;
    logic [3:0]           w_err;
    logic [DATA_BITS-1:0] w_data_nx, w_resp_nx;
    logic [CMD_BITS-1:0]  w_cmd_nx;

    // State register; reset parks the monitor in IDLE and silently drops any frame
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: SS_n high aborts any active phase, END waits for SS_n to rise
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_fall ? S_CMD : S_IDLE;
            S_CMD:   w_next = i_ss_n ? S_IDLE : w_last ? S_DATA : S_CMD;
            S_DATA:  w_next = i_ss_n ? S_IDLE : !w_last ? S_DATA : (r_cmd == READ_CMD) ? S_RESP : S_END;
            S_RESP:  w_next = i_ss_n ? S_IDLE : w_last ? S_END : S_RESP;
            S_END:   w_next = i_ss_n ? S_IDLE : S_END;
            default: w_next = S_IDLE;
        endcase
    end

    // Decode of phase boundaries, sampling strobes and the four violation conditions
    always_comb begin
        w_fall      = !i_ss_n && r_ss_q;
        w_cnt_last  = (r_state == S_CMD)  ? CW'(CMD_BITS - 1) :
                      (r_state == S_DATA) ? CW'(DATA_BITS - 1) : CW'(RESP_LAT + DATA_BITS - 1);
        w_last      = (r_cnt == w_cnt_last);
        w_window    = (r_state == S_CMD) || (r_state == S_DATA);
        w_resp_cap  = (r_state == S_RESP) && (r_cnt >= CW'(RESP_LAT));
        w_done      = !i_ss_n && w_last &&
                      (((r_state == S_DATA) && (r_cmd != READ_CMD)) || (r_state == S_RESP));
        w_resp_done = !i_ss_n && w_last && (r_state == S_RESP);
        w_cmd_nx    = CMD_BITS'({r_cmd, i_mosi});
        w_data_nx   = DATA_BITS'({r_data, i_mosi});
        w_resp_nx   = DATA_BITS'({r_resp, i_miso});
        w_err[0]    = i_rst_n && !r_rst_q && i_miso;
        w_err[1]    = w_window && (i_miso != r_miso_q);
        w_err[2]    = i_ss_n && (w_window || (r_state == S_RESP));
        w_err[3]    = (r_state == S_END) && !i_ss_n && (r_cnt == CW'(MAX_TAIL));
    end

    // Bit shifting, phase counter and frame result registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ss_q        <= 1'b1;
            r_miso_q      <= 1'b0;
            r_rst_q       <= 1'b0;
            r_cnt         <= '0;
            r_cmd         <= '0;
            r_data        <= '0;
            r_resp        <= '0;
            o_frame_done  <= 1'b0;
            o_frame_cmd   <= '0;
            o_frame_data  <= '0;
            o_frame_resp  <= '0;
            o_frame_count <= '0;
        end else begin
            r_ss_q       <= i_ss_n;
            r_miso_q     <= i_miso;
            r_rst_q      <= 1'b1;
            r_cnt        <= (r_state == S_IDLE || w_next != r_state) ? '0 :
                            (r_state == S_END && r_cnt == CW'(MAX_TAIL + 1)) ? r_cnt : r_cnt + CW'(1);
            o_frame_done <= w_done;
            if (r_state == S_CMD) r_cmd <= w_cmd_nx;
            if (r_state == S_DATA) r_data <= w_data_nx;
            if (w_resp_cap) r_resp <= w_resp_nx;
            if (w_done) begin
                o_frame_cmd   <= r_cmd;
                o_frame_data  <= (r_state == S_DATA) ? w_data_nx : r_data;
                o_frame_count <= o_frame_count + CNT_W'(1);
            end
            if (w_resp_done) o_frame_resp <= w_resp_nx;
        end
    end

    // Sticky flags and saturating error-cycle count; a new error outranks err_clr
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_err_flags <= '0;
            o_err_count <= '0;
        end else begin
            o_err_flags <= (i_err_clr ? 4'b0 : o_err_flags) | w_err;
            o_err_count <= (|w_err) ? (i_err_clr ? CNT_W'(1) :
                                       (o_err_count == {CNT_W{1'b1}}) ? o_err_count : o_err_count + CNT_W'(1)) :
                                      (i_err_clr ? '0 : o_err_count);
        end
    end

`ifdef SPI_MON_ASSERT_EN
    a_reset: assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_err[0])
        else $error("spi_mon reset violation: MISO high after reset, frame_count=%0d", o_frame_count);
    a_toggle: assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_err[1])
        else $error("spi_mon miso_toggle violation, frame_count=%0d", o_frame_count);
    a_early: assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_err[2])
        else $error("spi_mon early_end violation, frame_count=%0d", o_frame_count);
    a_overlong: assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_err[3])
        else $error("spi_mon overlong violation, frame_count=%0d", o_frame_count);
    c_reset:    cover property (@(posedge i_clk) disable iff (!i_rst_n) w_err[0]);
    c_toggle:   cover property (@(posedge i_clk) disable iff (!i_rst_n) w_err[1]);
    c_early:    cover property (@(posedge i_clk) disable iff (!i_rst_n) w_err[2]);
    c_overlong: cover property (@(posedge i_clk) disable iff (!i_rst_n) w_err[3]);
`else
`endif

endmodule

// File: doc/spi_protocol_monitor.md
# spi_protocol_monitor

Synthesizable, parametrised SPI frame monitor that sits passively on the wrapper's MOSI/MISO/SS_n lines. It tracks each SS_n-low frame with a state machine, decodes command and data bits from MOSI, captures read-response bits from MISO, and checks the protocol rules: MISO low after reset, MISO stable during the command/data window, and no early or overlong frames. Violations are reported as sticky flags and a saturating counter, so protocol checking works in hardware and in simulation.

## Interface
- CMD_BITS, 3: command bits on MOSI at frame start
- DATA_BITS, 8: address/data bits after the command; also the read-response length
- READ_CMD, 3'b111: command code that opens a response phase
- RESP_LAT, 1: cycles between the end of the data window and the first response bit
- MAX_TAIL, 4: cycles SS_n may stay low after the frame completes
- CNT_W, 8: width of err_count and frame_count

- clk  in  1  clock; every input is sampled on posedge
- rst_n  in  1  synchronous, active-low reset
- MOSI  in  1  master-to-slave data
- MISO  in  1  slave-to-master data
- SS_n  in  1  slave select, active low
- err_clr  in  1  clears err_flags and err_count
- frame_done  out  1  one-cycle pulse when a frame completes
- frame_cmd  out  CMD_BITS  command from the last completed frame
- frame_data  out  DATA_BITS  data from the last completed frame
- frame_resp  out  DATA_BITS  response from the last completed read frame
- err_flags  out  4  sticky flags: [0] reset, [1] miso_toggle, [2] early_end, [3] overlong
- err_count  out  CNT_W  saturating count of cycles in which any error fired
- frame_count  out  CNT_W  wrapping count of completed frames

## Operation
- Registers
  - ss_q: previous SS_n; reset value 1.
  - miso_q: previous MISO.
  - rst_q: previous rst_n; reset value 0.
- States: IDLE, CMD, DATA, RESP, END.
- Fall detection: the fall cycle t is any cycle with SS_n==0 and ss_q==1.
- IDLE: a fall at t moves the monitor to CMD. Bit counter is cleared.
- CMD: samples MOSI MSB-first over cycles t+1..t+CMD_BITS, then goes to DATA.
- DATA: samples MOSI MSB-first over the next DATA_BITS cycles. Afterwards:
  - cmd==READ_CMD: go to RESP.
  - otherwise: go to END and complete the frame.
- RESP: lasts RESP_LAT+DATA_BITS cycles. MISO is captured MSB-first in the last DATA_BITS of those cycles. Then go to END and complete the frame.
- Frame completion
  - The cycle after the frame's last sampled bit: frame_done=1.
  - frame_cmd and frame_data update; frame_resp updates only on read frames.
  - frame_count increments.
- END:
  - SS_n==1: go to IDLE.
  - SS_n==0 for more than MAX_TAIL cycles: set overlong once per frame and stay in END.
- miso_toggle: MISO!=miso_q in any CMD or DATA cycle. This is a stability window of CMD_BITS+DATA_BITS cycles after t. The first comparison is against MISO sampled at t.
- early_end: SS_n==1 in CMD, DATA or RESP. Go to IDLE, no frame_done, and partial fields are discarded.
- reset: rst_q==0, rst_n==1 and MISO!=0, i.e. MISO is high on the first cycle after reset.
- Error accounting
  - Several errors in one cycle set every matching flag but add only 1 to err_count.
  - err_count saturates at 2**CNT_W-1.
  - When err_clr coincides with a new error, the new error wins: the flag is set and err_count becomes 1.

## Timing
- All outputs are registered.
- While rst_n==0, every output is 0, the state is IDLE and ss_q is 1.
- If SS_n is already low on the first cycle out of reset, that cycle counts as a fall.
- Reset mid-frame aborts the frame silently: no flag, no frame_done.
- frame_done latency
  - Write frame: t+CMD_BITS+DATA_BITS+1.
  - Read frame: t+CMD_BITS+DATA_BITS+RESP_LAT+DATA_BITS+1.
- Sticky flags become visible the cycle after the violating sample.
- A new fall during END (SS_n rises, then falls) is handled like this:
  - The rise cycle moves END to IDLE.
  - The fall is detected on the next low cycle.
  - Back-to-back frames with one high cycle between them are legal.
- frame_count wraps from 2**CNT_W-1 to 0.

## Configuration
- SPI_MON_ASSERT_EN
  - Defined: simulation-only concurrent assertions (plus matching cover properties) issue $error for each of the four violations, naming the violation and the frame_count value.
  - Undefined: only err_flags and err_count report violations.
- RTL outputs are identical in both cases.

## Test plan
- Reset with MISO=1 held through the first cycle after release: err_flags=4'b0001, err_count=1. With MISO=0 instead, all outputs remain 0.
- Write frame with cmd=3'b000, data=8'hA5 and MISO held stable:
  - frame_done at t+12.
  - frame_cmd=3'b000, frame_data=8'hA5, frame_count=1.
  - err_flags=0.
- Read frame with cmd=3'b111 and data=8'h3C, MISO driving 8'hC3 after RESP_LAT: frame_resp=8'hC3, frame_done at t+21, no errors.
- MISO toggle at t+5 in a write frame: err_flags[1]=1, err_count=1, and the frame still completes.
- SS_n high at t+6: err_flags[2]=1, no frame_done, state back to IDLE. A following clean frame completes normally.
- SS_n held low 6 cycles after a write frame completes: err_flags[3]=1 once. Then err_clr=1 together with a fresh miso_toggle: err_flags=4'b0010, err_count=1.
